core_trap_ctrl: RTL and testbench

Trap and exception-return sequencer that sits directly upstream of the core CSR file. It accepts one trap, MRET or SRET request at a time from the commit stage and decides M- or S-mode delegation. It then produces the implicit CSR writes (sepc/scause/stval, mstatus, mepc/mcause, privilege mode) in a single cycle and hands the new PC to fetch through a valid/ready redirect handshake. The pipeline flush is held for the whole sequence.

---
 rtl/core_pkg.sv | 32 +++
 rtl/core_trap_target.sv | 45 ++++
 rtl/core_trap_ctrl.sv | 175 +++++++++++++++++
 tb/tb_core_trap_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types and mstatus bit positions used by the trap sequencer.
package core_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        PRV_U = 2'b00,
        PRV_S = 2'b01,
        PRV_M = 2'b11
    } prv_mode_t;

    typedef enum logic [1:0] {
        TRAP = 2'd0,
        MRET = 2'd1,
        SRET = 2'd2
    } trap_kind_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        REDIRECT = 2'd2
    } trap_state_t;

    localparam int unsigned MSTATUS_SIE    = 1;
    localparam int unsigned MSTATUS_SPIE   = 5;
    localparam int unsigned MSTATUS_SPP    = 8;
    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPRV   = 17;

endpackage

// File: rtl/core_trap_target.sv
// Combinational delegation decision and redirect target for a trap/xRET.
module core_trap_target
    import core_pkg::*;
(
    input  trap_kind_t kind,
    input  logic       is_irq,
    input  logic [4:0] cause,
    input  prv_mode_t  prv_mode,
    input  word_t      mtvec,
    input  word_t      stvec,
    input  word_t      mepc,
    input  word_t      sepc,
    input  word_t      medeleg,
    input  word_t      mideleg,
    output logic       to_s,
    output word_t      target_pc
);

    word_t tvec;
    word_t base;

    // Pick the handling mode and the PC fetch should resume at
    always_comb begin
        to_s      = 1'b0;
        tvec      = '0;
        base      = '0;
        target_pc = '0;
        case (kind)
            TRAP: begin
                to_s = (prv_mode != PRV_M) && (is_irq ? mideleg[cause] : medeleg[cause]);
                tvec = to_s ? stvec : mtvec;
                base = {tvec[31:2], 2'b00};
                // Only mode 1 vectors; modes 2 and 3 fall back to direct
                if (tvec[1:0] == 2'b01 && is_irq)
                    target_pc = base + {25'b0, cause, 2'b00};
                else
                    target_pc = base;
            end
            MRET:    target_pc = mepc;
            SRET:    target_pc = sepc;
            default: target_pc = '0;
        endcase
    end

endmodule

// File: rtl/core_trap_ctrl.sv
// Trap / MRET / SRET sequencer: accept, one-cycle implicit CSR write, redirect.
module core_trap_ctrl
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  trap_kind_t req_kind,
    input  logic       req_is_irq,
    input  logic [4:0] req_cause,
    input  word_t      req_epc,
    input  word_t      req_tval,
    input  prv_mode_t  prv_mode,
    input  word_t      csr_mstatus_ff,
    input  word_t      csr_medeleg_ff,
    input  word_t      csr_mideleg_ff,
    input  word_t      csr_mtvec_ff,
    input  word_t      csr_stvec_ff,
    input  word_t      csr_mepc_ff,
    input  word_t      csr_sepc_ff,
    output prv_mode_t  prv_mode_wd,
    output logic       prv_mode_we,
    output word_t      csr_sepc_wd,
    output logic       csr_sepc_we,
    output word_t      csr_scause_wd,
    output logic       csr_scause_we,
    output word_t      csr_stval_wd,
    output logic       csr_stval_we,
    output word_t      csr_mstatus_wd,
    output logic       csr_mstatus_we,
    output word_t      csr_mepc_wd,
    output logic       csr_mepc_we,
    output word_t      csr_mcause_wd,
    output logic       csr_mcause_we,
    output logic       flush,
    output logic       redirect_valid,
    output word_t      redirect_pc,
    input  logic       redirect_ready
);

    trap_state_t state;
    trap_kind_t  kind_q;
    logic        irq_q;
    logic [4:0]  cause_q;
    word_t       epc_q;
    word_t       tval_q;
    prv_mode_t   prv_q;
    logic        to_s_q;
    word_t       target_q;

    logic        to_s_c;
    word_t       target_c;
    word_t       mstatus_nx;

    core_trap_target u_target (
        .kind      (req_kind),
        .is_irq    (req_is_irq),
        .cause     (req_cause),
        .prv_mode  (prv_mode),
        .mtvec     (csr_mtvec_ff),
        .stvec     (csr_stvec_ff),
        .mepc      (csr_mepc_ff),
        .sepc      (csr_sepc_ff),
        .medeleg   (csr_medeleg_ff),
        .mideleg   (csr_mideleg_ff),
        .to_s      (to_s_c),
        .target_pc (target_c)
    );

    // Sequencer state and request capture at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            kind_q   <= TRAP;
            irq_q    <= 1'b0;
            cause_q  <= '0;
            epc_q    <= '0;
            tval_q   <= '0;
            prv_q    <= PRV_M;
            to_s_q   <= 1'b0;
            target_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        kind_q   <= req_kind;
                        irq_q    <= req_is_irq;
                        cause_q  <= req_cause;
                        epc_q    <= req_epc;
                        tval_q   <= req_tval;
                        prv_q    <= prv_mode;
                        to_s_q   <= to_s_c;
                        target_q <= target_c;
                        state    <= WRITE;
                    end
                end
                WRITE:    state <= REDIRECT;
                REDIRECT: if (redirect_ready) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign req_ready      = (state == IDLE);
    assign redirect_valid = (state == REDIRECT);
    assign redirect_pc    = target_q;
    // Flush covers the accept cycle, which is still IDLE
    assign flush          = (state != IDLE) || req_valid;

    // Implicit CSR writes, asserted only during the WRITE cycle
    always_comb begin
        prv_mode_wd    = PRV_M;
        prv_mode_we    = 1'b0;
        csr_sepc_wd    = '0;
        csr_sepc_we    = 1'b0;
        csr_scause_wd  = '0;
        csr_scause_we  = 1'b0;
        csr_stval_wd   = '0;
        csr_stval_we   = 1'b0;
        csr_mstatus_wd = '0;
        csr_mstatus_we = 1'b0;
        csr_mepc_wd    = '0;
        csr_mepc_we    = 1'b0;
        csr_mcause_wd  = '0;
        csr_mcause_we  = 1'b0;
        mstatus_nx     = csr_mstatus_ff;
        if (state == WRITE) begin
            prv_mode_we    = 1'b1;
            csr_mstatus_we = 1'b1;
            case (kind_q)
                TRAP: begin
                    if (to_s_q) begin
                        csr_sepc_we   = 1'b1;
                        csr_sepc_wd   = epc_q;
                        csr_scause_we = 1'b1;
                        csr_scause_wd = {irq_q, 26'b0, cause_q};
                        csr_stval_we  = 1'b1;
                        csr_stval_wd  = tval_q;
                        mstatus_nx[MSTATUS_SPIE] = csr_mstatus_ff[MSTATUS_SIE];
                        mstatus_nx[MSTATUS_SIE]  = 1'b0;
                        mstatus_nx[MSTATUS_SPP]  = prv_q[0];
                        prv_mode_wd = PRV_S;
                    end else begin
                        csr_mepc_we   = 1'b1;
                        csr_mepc_wd   = epc_q;
                        csr_mcause_we = 1'b1;
                        csr_mcause_wd = {irq_q, 26'b0, cause_q};
                        mstatus_nx[MSTATUS_MPIE] = csr_mstatus_ff[MSTATUS_MIE];
                        mstatus_nx[MSTATUS_MIE]  = 1'b0;
                        mstatus_nx[MSTATUS_MPP_LO +: 2] = prv_q;
                        prv_mode_wd = PRV_M;
                    end
                end
                MRET: begin
                    prv_mode_wd = prv_mode_t'(csr_mstatus_ff[MSTATUS_MPP_LO +: 2]);
                    mstatus_nx[MSTATUS_MIE]  = csr_mstatus_ff[MSTATUS_MPIE];
                    mstatus_nx[MSTATUS_MPIE] = 1'b1;
                    mstatus_nx[MSTATUS_MPP_LO +: 2] = PRV_U;
                    if (csr_mstatus_ff[MSTATUS_MPP_LO +: 2] != PRV_M)
                        mstatus_nx[MSTATUS_MPRV] = 1'b0;
                end
                SRET: begin
                    prv_mode_wd = prv_mode_t'({1'b0, csr_mstatus_ff[MSTATUS_SPP]});
                    mstatus_nx[MSTATUS_SIE]  = csr_mstatus_ff[MSTATUS_SPIE];
                    mstatus_nx[MSTATUS_SPIE] = 1'b1;
                    mstatus_nx[MSTATUS_SPP]  = 1'b0;
                end
                default: ;
            endcase
            csr_mstatus_wd = mstatus_nx;
        end
    end

endmodule

// File: tb/tb_core_trap_ctrl.sv
// Self-checking bench for core_trap_ctrl: directed cases plus randomized requests.
module tb_core_trap_ctrl;
    import core_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    trap_kind_t req_kind;
    logic       req_is_irq;
    logic [4:0] req_cause;
    word_t      req_epc, req_tval;
    prv_mode_t  prv_mode;
    word_t      csr_mstatus_ff, csr_medeleg_ff, csr_mideleg_ff;
    word_t      csr_mtvec_ff, csr_stvec_ff, csr_mepc_ff, csr_sepc_ff;
    prv_mode_t  prv_mode_wd;
    logic       prv_mode_we;
    word_t      csr_sepc_wd, csr_scause_wd, csr_stval_wd, csr_mstatus_wd, csr_mepc_wd, csr_mcause_wd;
    logic       csr_sepc_we, csr_scause_we, csr_stval_we, csr_mstatus_we, csr_mepc_we, csr_mcause_we;
    logic       flush, redirect_valid, redirect_ready;
    word_t      redirect_pc;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    word_t last_pc, last_mcause, last_ms;
    logic [1:0] last_prv;
    logic last_mepc_we, last_sepc_we;

    core_trap_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_is_irq(req_is_irq), .req_cause(req_cause), .req_epc(req_epc), .req_tval(req_tval),
        .prv_mode(prv_mode),
        .csr_mstatus_ff(csr_mstatus_ff), .csr_medeleg_ff(csr_medeleg_ff), .csr_mideleg_ff(csr_mideleg_ff),
        .csr_mtvec_ff(csr_mtvec_ff), .csr_stvec_ff(csr_stvec_ff), .csr_mepc_ff(csr_mepc_ff), .csr_sepc_ff(csr_sepc_ff),
        .prv_mode_wd(prv_mode_wd), .prv_mode_we(prv_mode_we),
        .csr_sepc_wd(csr_sepc_wd), .csr_sepc_we(csr_sepc_we),
        .csr_scause_wd(csr_scause_wd), .csr_scause_we(csr_scause_we),
        .csr_stval_wd(csr_stval_wd), .csr_stval_we(csr_stval_we),
        .csr_mstatus_wd(csr_mstatus_wd), .csr_mstatus_we(csr_mstatus_we),
        .csr_mepc_wd(csr_mepc_wd), .csr_mepc_we(csr_mepc_we),
        .csr_mcause_wd(csr_mcause_wd), .csr_mcause_we(csr_mcause_we),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        trap_kind_t  kind;
        logic        irq;
        logic [4:0]  cause;
        word_t       epc, tval;
        prv_mode_t   prv;
        word_t       ms_acc, ms_wr;
        word_t       medeleg, mideleg, mtvec, stvec, mepc, sepc;
        int unsigned bp;
    } req_t;

    typedef struct {
        logic  sepc_we, scause_we, stval_we, mstatus_we, mepc_we, mcause_we, prv_we;
        word_t sepc, scause, stval, mstatus, mepc, mcause, pc;
        logic [1:0] prv;
    } exp_t;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: mstatus handled as named fields, then reassembled
    function automatic exp_t model(input req_t r);
        exp_t e;
        word_t ms, tvec, base, code;
        int unsigned sie, spie, spp, mie, mpie, mpp, mprv;
        bit to_s;
        e = '{default: '0};
        ms   = r.ms_wr;
        sie  = (ms >> 1) & 1;  spie = (ms >> 5) & 1;  spp  = (ms >> 8) & 1;
        mie  = (ms >> 3) & 1;  mpie = (ms >> 7) & 1;  mpp  = (ms >> 11) & 3;
        mprv = (ms >> 17) & 1;
        to_s = (r.kind == TRAP) && (r.prv != PRV_M) &&
               ((((r.irq ? r.mideleg : r.medeleg) >> r.cause) & 32'd1) == 32'd1);
        code = (r.irq ? 32'h8000_0000 : 32'h0) + word_t'(r.cause);
        case (r.kind)
            TRAP: begin
                if (to_s) begin
                    e.sepc_we = 1; e.sepc = r.epc;
                    e.scause_we = 1; e.scause = code;
                    e.stval_we = 1; e.stval = r.tval;
                    spie = sie; sie = 0; spp = (r.prv == PRV_S) ? 1 : 0;
                    e.prv = 2'b01;
                    tvec = r.stvec;
                end else begin
                    e.mepc_we = 1; e.mepc = r.epc;
                    e.mcause_we = 1; e.mcause = code;
                    mpie = mie; mie = 0; mpp = r.prv;
                    e.prv = 2'b11;
                    tvec = r.mtvec;
                end
                base = tvec - (tvec % 4);
                e.pc = ((tvec % 4) == 1 && r.irq) ? base + word_t'(r.cause) * 4 : base;
            end
            MRET: begin
                e.prv = 2'(mpp);
                if (mpp != 3) mprv = 0;
                mie = mpie; mpie = 1; mpp = 0;
                e.pc = r.mepc;
            end
            default: begin
                e.prv = 2'(spp);
                sie = spie; spie = 1; spp = 0;
                e.pc = r.sepc;
            end
        endcase
        e.mstatus_we = 1;
        e.prv_we = 1;
        e.mstatus = (ms & ~32'h0002_19AA) | (word_t'(sie) << 1) | (word_t'(spie) << 5) |
                    (word_t'(spp) << 8) | (word_t'(mie) << 3) | (word_t'(mpie) << 7) |
                    (word_t'(mpp) << 11) | (word_t'(mprv) << 17);
        return e;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.kind  = trap_kind_t'($urandom_range(0, 2));
        r.irq   = 1'($urandom);
        r.cause = 5'($urandom);
        r.epc   = $urandom; r.tval = $urandom;
        case ($urandom_range(0, 2))
            0:       r.prv = PRV_U;
            1:       r.prv = PRV_S;
            default: r.prv = PRV_M;
        endcase
        r.ms_acc  = $urandom; r.ms_wr = $urandom;
        r.medeleg = $urandom; r.mideleg = $urandom;
        r.mtvec   = $urandom; r.stvec = $urandom;
        r.mepc    = $urandom; r.sepc = $urandom;
        r.bp      = $urandom_range(0, 3);
        return r;
    endfunction

    function automatic logic any_we();
        return prv_mode_we | csr_sepc_we | csr_scause_we | csr_stval_we |
               csr_mstatus_we | csr_mepc_we | csr_mcause_we;
    endfunction

    // Entered just after a rising edge with the DUT idle; leaves the same way
    task automatic run_req(input req_t r);
        exp_t e;
        e = model(r);
        req_valid = 1; req_kind = r.kind; req_is_irq = r.irq; req_cause = r.cause;
        req_epc = r.epc; req_tval = r.tval; prv_mode = r.prv;
        csr_mstatus_ff = r.ms_acc; csr_medeleg_ff = r.medeleg; csr_mideleg_ff = r.mideleg;
        csr_mtvec_ff = r.mtvec; csr_stvec_ff = r.stvec; csr_mepc_ff = r.mepc; csr_sepc_ff = r.sepc;
        @(negedge clk);
        chk1("accept_req_ready", req_ready, 1'b1);
        chk1("accept_flush", flush, 1'b1);
        chk1("accept_no_we", any_we(), 1'b0);
        @(posedge clk); #1;
        // Scramble everything the DUT should have latched or sample later
        req_valid = 0; req_kind = trap_kind_t'($urandom_range(0, 2)); req_is_irq = 1'($urandom);
        req_cause = 5'($urandom); req_epc = $urandom; req_tval = $urandom; prv_mode = PRV_U;
        csr_mstatus_ff = r.ms_wr; csr_medeleg_ff = $urandom; csr_mideleg_ff = $urandom;
        csr_mtvec_ff = $urandom; csr_stvec_ff = $urandom; csr_mepc_ff = $urandom; csr_sepc_ff = $urandom;
        redirect_ready = 1'($urandom);
        @(negedge clk);
        chk1("wr_req_ready", req_ready, 1'b0);
        chk1("wr_flush", flush, 1'b1);
        chk1("wr_redirect_valid", redirect_valid, 1'b0);
        chk1("wr_prv_we", prv_mode_we, e.prv_we);
        chk("wr_prv_wd", 32'(prv_mode_wd), 32'(e.prv));
        chk1("wr_mstatus_we", csr_mstatus_we, e.mstatus_we);
        chk("wr_mstatus_wd", csr_mstatus_wd, e.mstatus);
        chk1("wr_sepc_we", csr_sepc_we, e.sepc_we);
        chk1("wr_scause_we", csr_scause_we, e.scause_we);
        chk1("wr_stval_we", csr_stval_we, e.stval_we);
        chk1("wr_mepc_we", csr_mepc_we, e.mepc_we);
        chk1("wr_mcause_we", csr_mcause_we, e.mcause_we);
        if (e.sepc_we) begin
            chk("wr_sepc_wd", csr_sepc_wd, e.sepc);
            chk("wr_scause_wd", csr_scause_wd, e.scause);
            chk("wr_stval_wd", csr_stval_wd, e.stval);
        end
        if (e.mepc_we) begin
            chk("wr_mepc_wd", csr_mepc_wd, e.mepc);
            chk("wr_mcause_wd", csr_mcause_wd, e.mcause);
        end
        last_ms = csr_mstatus_wd; last_prv = prv_mode_wd; last_mcause = csr_mcause_wd;
        last_mepc_we = csr_mepc_we; last_sepc_we = csr_sepc_we;
        for (int unsigned i = 0; i <= r.bp; i++) begin
            @(posedge clk); #1;
            redirect_ready = (i == r.bp);
            @(negedge clk);
            chk1("rd_valid", redirect_valid, 1'b1);
            chk("rd_pc", redirect_pc, e.pc);
            chk1("rd_flush", flush, 1'b1);
            chk1("rd_req_ready", req_ready, 1'b0);
            chk1("rd_no_we", any_we(), 1'b0);
        end
        last_pc = redirect_pc;
        @(posedge clk); #1;
        redirect_ready = 0;
    endtask

    task automatic idle_cycle();
        redirect_ready = 1'($urandom);
        @(negedge clk);
        chk1("idle_req_ready", req_ready, 1'b1);
        chk1("idle_redirect_valid", redirect_valid, 1'b0);
        chk1("idle_flush", flush, 1'b0);
        chk1("idle_no_we", any_we(), 1'b0);
        @(posedge clk); #1;
        redirect_ready = 0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk1({tag, "_req_ready"}, req_ready, 1'b1);
        chk1({tag, "_any_we"}, any_we(), 1'b0);
        chk({tag, "_wd_or"}, csr_sepc_wd | csr_scause_wd | csr_stval_wd | csr_mstatus_wd |
            csr_mepc_wd | csr_mcause_wd, 32'h0);
        chk({tag, "_prv_wd"}, 32'(prv_mode_wd), 32'h3);
        chk1({tag, "_flush"}, flush, 1'b0);
        chk1({tag, "_redirect_valid"}, redirect_valid, 1'b0);
        chk({tag, "_redirect_pc"}, redirect_pc, 32'h0);
    endtask

    initial begin
        req_t r;
        rst_n = 0; req_valid = 0; req_kind = TRAP; req_is_irq = 0; req_cause = 0;
        req_epc = 0; req_tval = 0; prv_mode = PRV_M; redirect_ready = 0;
        csr_mstatus_ff = 0; csr_medeleg_ff = 0; csr_mideleg_ff = 0;
        csr_mtvec_ff = 0; csr_stvec_ff = 0; csr_mepc_ff = 0; csr_sepc_ff = 0;
        #1;
        chk_reset_values("reset");
        @(posedge clk); #1;
        rst_n = 1;
        idle_cycle();

        // M-mode illegal instruction
        r = rand_req(); r.kind = TRAP; r.irq = 0; r.cause = 5'd2; r.epc = 32'h8000_0010;
        r.prv = PRV_M; r.mtvec = 32'h8000_0100; r.bp = 0;
        run_req(r);
        chk("tp_illegal_pc", last_pc, 32'h8000_0100);
        chk("tp_illegal_mcause", last_mcause, 32'h2);
        chk("tp_illegal_mpp", 32'(last_ms[12:11]), 32'h3);
        chk1("tp_illegal_mie", last_ms[3], 1'b0);

        // Delegated ecall from U
        r = rand_req(); r.kind = TRAP; r.irq = 0; r.cause = 5'd8; r.prv = PRV_U;
        r.medeleg = 32'h100; r.stvec = 32'hC000_0000; r.ms_acc = 32'h2; r.ms_wr = 32'h2; r.bp = 1;
        run_req(r);
        chk("tp_ecall_ms", last_ms, 32'h20);
        chk("tp_ecall_prv", 32'(last_prv), 32'h1);
        chk1("tp_ecall_no_mepc", last_mepc_we, 1'b0);
        chk1("tp_ecall_sepc", last_sepc_we, 1'b1);
        chk("tp_ecall_pc", last_pc, 32'hC000_0000);

        // Vectored M interrupt
        r = rand_req(); r.kind = TRAP; r.irq = 1; r.cause = 5'd7; r.prv = PRV_M;
        r.mtvec = 32'h8000_0001; r.bp = 0;
        run_req(r);
        chk("tp_vec_pc", last_pc, 32'h8000_001C);
        chk("tp_vec_mcause", last_mcause, 32'h8000_0007);

        // MRET back to U with MPRV set
        r = rand_req(); r.kind = MRET; r.ms_acc = 32'h0002_0080; r.ms_wr = 32'h0002_0080;
        r.mepc = 32'h1000; r.bp = 0;
        run_req(r);
        chk("tp_mret_ms", last_ms, 32'h88);
        chk("tp_mret_prv", 32'(last_prv), 32'h0);
        chk("tp_mret_pc", last_pc, 32'h1000);

        // Delegated vectored interrupt at cause 31 with target wrap
        r = rand_req(); r.kind = TRAP; r.irq = 1; r.cause = 5'd31; r.prv = PRV_S;
        r.mideleg = 32'h8000_0000; r.stvec = 32'hFFFF_FFC1; r.bp = 2;
        run_req(r);
        chk("tp_wrap_pc", last_pc, 32'h0000_003C);

        // Redirect backpressure
        r = rand_req(); r.bp = 5;
        run_req(r);
        idle_cycle();

        // Reset asserted during WRITE
        r = rand_req();
        req_valid = 1; req_kind = r.kind; req_is_irq = r.irq; req_cause = r.cause;
        req_epc = r.epc; prv_mode = r.prv; csr_mtvec_ff = r.mtvec; csr_mepc_ff = r.mepc;
        @(posedge clk); #1;
        req_valid = 0;
        @(negedge clk);
        chk1("rst_mid_we_before", csr_mstatus_we, 1'b1);
        #1 rst_n = 0;
        #1;
        chk_reset_values("rst_mid");
        @(posedge clk); #1;
        rst_n = 1;
        idle_cycle();

        // Randomized requests, mixing back-to-back and idle gaps
        for (int unsigned n = 0; n < 40; n++) begin
            run_req(rand_req());
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
